imem_prog: RTL and testbench
============================

Name: imem_prog

Overview:
- Parametrised instruction memory for the RISC-V single-cycle core, successor to the fixed 256-word hard-coded IMEM.
- After reset it clears itself to NOP over DEPTH cycles.
- It accepts a byte-serial program download (e.g. from a UART receiver) over a valid/ready handshake, and serves fetches with alignment/range fault detection and selectable combinational or registered read.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, >= 4; IDX_W = clog2(DEPTH) derived internally.
- NOP, 32'h00000013, fill value and value returned on faulted/unavailable fetch (addi x0,x0,0).
- READ_REG, 0, 0 = instruction combinational from PC_Out; 1 = instruction/instr_fault registered, 1-cycle latency.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- PC_Out  in  32  byte address of fetch.
- instruction  out  32  fetched word.
- instr_fault  out  1  fetch misaligned or out of range.
- mem_ready  out  1  high only in RUN state.
- ld_start  in  1  request program download (sampled in RUN only).
- ld_valid  in  1  ld_byte valid.
- ld_byte  in  8  download byte.
- ld_last  in  1  marks final byte, qualified by ld_valid.
- ld_ready  out  1  high only in LOAD state.
- ld_count  out  IDX_W+1  words written in the current/last download.
- ld_overflow  out  1  sticky: bytes arrived beyond DEPTH words.

Behaviour:
- States: CLEAR, RUN, LOAD.
- Reset (rst=1 at clk edge, from any state, including mid-LOAD or mid-CLEAR):
  - State goes to CLEAR; clr_ptr=0, ld_ptr=0, byte_cnt=0, assembly reg=0.
  - ld_count=0, ld_overflow=0, mem_ready=0, ld_ready=0.
  - Registered outputs (READ_REG=1): instruction=NOP, instr_fault=0.
- CLEAR:
  - Each cycle writes NOP to mem[clr_ptr], then clr_ptr++.
  - After the write to DEPTH-1, the next state is RUN.
  - mem_ready first reads 1 exactly DEPTH cycles after the cycle in which rst was sampled low.
  - ld_start is ignored.
- RUN:
  - Fetches served; mem_ready=1.
  - ld_start=1 → LOAD next cycle; ld_ptr=0, byte_cnt=0, ld_count=0, ld_overflow=0.
  - Memory contents are retained across LOAD.
- LOAD:
  - ld_ready=1; a byte is accepted when ld_valid & ld_ready.
  - Little-endian assembly: byte k (0..3) goes to bits [8k+7:8k].
  - On the 4th byte, the word is written to mem[ld_ptr]; ld_ptr++, ld_count++, byte_cnt=0.
  - Accepted byte with ld_last=1:
    - If byte_cnt+1 < 4, the partial word is written with unfilled upper bytes = 0 and ld_count increments.
    - State returns to RUN next cycle.
  - Overflow: once ld_ptr == DEPTH, further accepted bytes are discarded and ld_overflow sets (sticky until next ld_start or rst). ld_ready stays 1 until ld_last is accepted.
  - ld_start is ignored while in LOAD.
- Fetch:
  - idx = PC_Out[IDX_W+1:2].
  - fault = (PC_Out[1:0] != 0) | (PC_Out[31:2] >= DEPTH).
  - Output = NOP when fault, or state != RUN; otherwise mem[idx].
  - instr_fault reflects fault in all states.
  - READ_REG=0: both outputs combinational, same cycle.
  - READ_REG=1: both outputs registered, value for PC_Out sampled at edge N is visible after edge N.
- Write/read collision: a fetch is never served during LOAD (NOP output), so no read-during-write hazard exists.
- Only one writer per cycle: the CLEAR and LOAD writes are mutually exclusive by state.

Test Plan:
- Reset release, DEPTH=16: mem_ready=0 for 16 cycles then 1. Fetch PC_Out=0x8 → instruction=0x00000013, instr_fault=0.
- Download:
  - ld_start, then bytes 33 05 34 40, then 93 0A 2B 01 with ld_last on the final byte.
  - ld_count=2, state back in RUN.
  - PC_Out=0 → 0x40340533 (add-family); PC_Out=4 → 0x012B0A93.
- Partial word: download bytes 13 05 with ld_last → ld_count=1; PC_Out=0 → 0x00000513.
- Overflow, DEPTH=4:
  - Stream 20 bytes, ld_last on the 20th.
  - ld_count=4, ld_overflow=1, ld_ready held until ld_last.
  - The next ld_start clears ld_overflow.
- Faults:
  - PC_Out=0x2 → instr_fault=1, NOP.
  - PC_Out=0x400 with DEPTH=256 → instr_fault=1, NOP.
  - Repeat with READ_REG=1: both appear one cycle later.
- rst asserted mid-LOAD after 6 bytes → CLEAR; afterwards all words read NOP, ld_count=0, ld_ready=0.

Source files
------------

// File: rtl/imem_prog.sv
// Instruction memory with self-clear, byte-serial program download and
// fault-checked fetch (combinational or registered read).
module imem_prog #(
    parameter int unsigned DEPTH    = 256,
    parameter logic [31:0] NOP      = 32'h0000_0013,
    parameter bit          READ_REG = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              PC_Out,
    output logic [31:0]              instruction,
    output logic                     instr_fault,
    output logic                     mem_ready,
    input  logic                     ld_start,
    input  logic                     ld_valid,
    input  logic [7:0]               ld_byte,
    input  logic                     ld_last,
    output logic                     ld_ready,
    output logic [$clog2(DEPTH):0]   ld_count,
    output logic                     ld_overflow
);

    localparam int unsigned          IDX_W    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W:0]       FULL_CNT = (IDX_W + 1)'(DEPTH);

    typedef enum logic [1:0] {CLEAR, RUN, LOAD} state_t;

    state_t             state, state_next;
    logic [31:0]        mem [DEPTH];
    logic [IDX_W-1:0]   clr_ptr;
    logic [IDX_W:0]     ld_ptr;
    logic [1:0]         byte_cnt;
    logic [31:0]        asm_word;

    logic               accept, room, word_done, wr_en;
    logic [IDX_W-1:0]   wr_addr;
    logic [31:0]        wr_data, assembled;
    logic               fault;
    logic [31:0]        fetch_word;

    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = (state == LOAD) & ld_valid;
        room       = (ld_ptr != FULL_CNT);
        assembled  = asm_word | ({24'b0, ld_byte} << {byte_cnt, 3'b000});
        word_done  = accept & room & (ld_last | (byte_cnt == 2'd3));
        wr_en      = 1'b0;
        wr_addr    = clr_ptr;
        wr_data    = NOP;
        case (state)
            CLEAR: begin
                wr_en = 1'b1;
                if (clr_ptr == LAST_IDX) state_next = RUN;
            end
            RUN: begin
                if (ld_start) state_next = LOAD;
            end
            LOAD: begin
                wr_en   = word_done;
                wr_addr = ld_ptr[IDX_W-1:0];
                wr_data = assembled;
                if (accept & ld_last) state_next = RUN;
            end
            default: state_next = CLEAR;
        endcase
    end

    // Bytes beyond the last word are dropped but still accepted, so the
    // sender always drains through ld_last.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_ptr     <= '0;
            ld_ptr      <= '0;
            byte_cnt    <= '0;
            asm_word    <= '0;
            ld_overflow <= 1'b0;
        end else begin
            case (state)
                CLEAR: clr_ptr <= clr_ptr + 1'b1;
                RUN: begin
                    if (ld_start) begin
                        ld_ptr      <= '0;
                        byte_cnt    <= '0;
                        asm_word    <= '0;
                        ld_overflow <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (!room) begin
                            ld_overflow <= 1'b1;
                        end else if (word_done) begin
                            ld_ptr   <= ld_ptr + 1'b1;
                            byte_cnt <= '0;
                            asm_word <= '0;
                        end else begin
                            asm_word <= assembled;
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[wr_addr] <= wr_data;
    end

    assign mem_ready = (state == RUN);
    assign ld_ready  = (state == LOAD);
    assign ld_count  = ld_ptr;

    always_comb begin
        fault      = (PC_Out[1:0] != 2'b00) | (PC_Out[31:2] >= 30'(DEPTH));
        fetch_word = (fault || state != RUN) ? NOP : mem[PC_Out[IDX_W+1:2]];
    end

    generate
        if (READ_REG) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    instruction <= NOP;
                    instr_fault <= 1'b0;
                end else begin
                    instruction <= fetch_word;
                    instr_fault <= fault;
                end
            end
        end else begin : g_comb
            assign instruction = fetch_word;
            assign instr_fault = fault;
        end
    endgenerate

endmodule

// File: tb/tb_imem_prog.sv
// Bench for imem_prog: three instances (DEPTH 16/4 combinational, DEPTH 256
// registered) driven in parallel and compared against a word-array model.
module tb_imem_prog;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC_Out;
    logic        ld_start, ld_valid, ld_last;
    logic [7:0]  ld_byte;

    logic [31:0] instr [3];
    logic        flt [3], mrdy [3], lrdy [3], ovf [3];
    logic [8:0]  cnt [3];
    logic [4:0]  c0;
    logic [2:0]  c1;
    logic [8:0]  c2;

    int unsigned dep [3] = '{16, 4, 256};
    logic [31:0] mdl [3][256];
    int unsigned n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    imem_prog #(.DEPTH(16), .NOP(NOP), .READ_REG(1'b0)) u16 (
        .clk(clk), .rst(rst), .PC_Out(PC_Out), .instruction(instr[0]),
        .instr_fault(flt[0]), .mem_ready(mrdy[0]), .ld_start(ld_start),
        .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
        .ld_ready(lrdy[0]), .ld_count(c0), .ld_overflow(ovf[0]));

    imem_prog #(.DEPTH(4), .NOP(NOP), .READ_REG(1'b0)) u4 (
        .clk(clk), .rst(rst), .PC_Out(PC_Out), .instruction(instr[1]),
        .instr_fault(flt[1]), .mem_ready(mrdy[1]), .ld_start(ld_start),
        .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
        .ld_ready(lrdy[1]), .ld_count(c1), .ld_overflow(ovf[1]));

    imem_prog #(.DEPTH(256), .NOP(NOP), .READ_REG(1'b1)) u256r (
        .clk(clk), .rst(rst), .PC_Out(PC_Out), .instruction(instr[2]),
        .instr_fault(flt[2]), .mem_ready(mrdy[2]), .ld_start(ld_start),
        .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
        .ld_ready(lrdy[2]), .ld_count(c2), .ld_overflow(ovf[2]));

    assign cnt[0] = {4'b0, c0};
    assign cnt[1] = {6'b0, c1};
    assign cnt[2] = c2;

    typedef struct {
        logic [31:0] pc;
        logic [2:0]  f;     // expected fault, bit d for instance d
    } fvec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int unsigned mn(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

    task automatic fetch_check(input logic [31:0] pc);
        PC_Out = pc;
        tick();
        for (int d = 0; d < 3; d++) begin
            logic ef;
            ef = (pc[1:0] != 2'b00) || ((pc >> 2) >= dep[d]);
            chk($sformatf("u%0d fault pc=%h", d, pc), 32'(flt[d]), 32'(ef));
            chk($sformatf("u%0d instr pc=%h", d, pc), instr[d], ef ? NOP : mdl[d][pc >> 2]);
        end
    endtask

    task automatic sweep();
        for (int unsigned w = 0; w < 256; w++) fetch_check(w * 4);
    endtask

    task automatic reset_and_clear();
        rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; PC_Out = 32'h2;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("u%0d rst mem_ready", d), 32'(mrdy[d]), 32'd0);
            chk($sformatf("u%0d rst ld_ready", d), 32'(lrdy[d]), 32'd0);
            chk($sformatf("u%0d rst ld_count", d), 32'(cnt[d]), 32'd0);
            chk($sformatf("u%0d rst ld_overflow", d), 32'(ovf[d]), 32'd0);
            chk($sformatf("u%0d rst instr", d), instr[d], NOP);
        end
        chk("u16 rst comb fault", 32'(flt[0]), 32'd1);
        chk("u256r rst reg fault", 32'(flt[2]), 32'd0);
        rst = 1'b0;
        PC_Out = 32'h8;
        // ld_start during the first CLEAR cycles must be ignored
        for (int unsigned cyc = 1; cyc <= 260; cyc++) begin
            ld_start = (cyc <= 3);
            tick();
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("u%0d mem_ready cyc %0d", d, cyc), 32'(mrdy[d]), 32'(cyc >= dep[d]));
                chk($sformatf("u%0d ld_ready cyc %0d", d, cyc), 32'(lrdy[d]), 32'd0);
            end
        end
        ld_start = 1'b0;
        for (int d = 0; d < 3; d++)
            for (int w = 0; w < 256; w++) mdl[d][w] = NOP;
    endtask

    task automatic load(input logic [7:0] q[$], input bit with_last);
        int unsigned n;
        n = q.size();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("u%0d start ld_ready", d), 32'(lrdy[d]), 32'd1);
            chk($sformatf("u%0d start ld_count", d), 32'(cnt[d]), 32'd0);
            chk($sformatf("u%0d start ld_overflow", d), 32'(ovf[d]), 32'd0);
        end
        for (int unsigned i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                ld_valid = 1'b0;
                ld_byte  = 8'($urandom);
                ld_last  = 1'($urandom);
                ld_start = 1'($urandom);
                tick();
                for (int d = 0; d < 3; d++)
                    chk($sformatf("u%0d gap ld_ready", d), 32'(lrdy[d]), 32'd1);
            end
            ld_valid = 1'b1;
            ld_byte  = q[i];
            ld_last  = with_last && (i == n - 1);
            ld_start = 1'($urandom);
            tick();
            if (!(with_last && i == n - 1)) begin
                for (int d = 0; d < 3; d++) begin
                    chk($sformatf("u%0d byte %0d ld_ready", d, i), 32'(lrdy[d]), 32'd1);
                    chk($sformatf("u%0d byte %0d ld_count", d, i), 32'(cnt[d]),
                        mn((i + 1) / 4, dep[d]));
                    chk($sformatf("u%0d byte %0d ld_overflow", d, i), 32'(ovf[d]),
                        32'((i + 1) > 4 * dep[d]));
                end
            end
        end
        ld_valid = 1'b0; ld_last = 1'b0; ld_start = 1'b0;
        if (with_last) begin
            for (int d = 0; d < 3; d++) begin
                for (int unsigned i = 0; i < n; i++) begin
                    if (i / 4 < dep[d]) begin
                        if (i % 4 == 0) mdl[d][i / 4] = '0;
                        mdl[d][i / 4][8 * (i % 4) +: 8] = q[i];
                    end
                end
                chk($sformatf("u%0d end ld_ready", d), 32'(lrdy[d]), 32'd0);
                chk($sformatf("u%0d end mem_ready", d), 32'(mrdy[d]), 32'd1);
                chk($sformatf("u%0d end ld_count", d), 32'(cnt[d]), mn((n + 3) / 4, dep[d]));
                chk($sformatf("u%0d end ld_overflow", d), 32'(ovf[d]), 32'(n > 4 * dep[d]));
            end
        end
    endtask

    initial begin
        fvec_t       fv [13];
        logic [7:0]  q [$];
        logic [31:0] lat_pc [2];

        fv = '{
            '{32'h0000_0000, 3'b000}, '{32'h0000_0002, 3'b111}, '{32'h0000_0001, 3'b111},
            '{32'h0000_0003, 3'b111}, '{32'h0000_0008, 3'b000}, '{32'h0000_000C, 3'b000},
            '{32'h0000_0010, 3'b010}, '{32'h0000_003C, 3'b010}, '{32'h0000_0040, 3'b011},
            '{32'h0000_03FC, 3'b011}, '{32'h0000_0400, 3'b111}, '{32'h8000_0000, 3'b111},
            '{32'h0000_0402, 3'b111}};
        ld_byte = 8'h00;

        reset_and_clear();
        sweep();

        q = '{8'h33, 8'h05, 8'h34, 8'h40, 8'h93, 8'h0A, 8'h2B, 8'h01};
        load(q, 1'b1);
        fetch_check(32'h0);
        chk("u16 add word", instr[0], 32'h4034_0533);
        fetch_check(32'h4);
        chk("u16 addi word", instr[0], 32'h012B_0A93);

        q = '{8'h13, 8'h05};
        load(q, 1'b1);
        fetch_check(32'h0);
        chk("u4 partial word", instr[1], 32'h0000_0513);
        fetch_check(32'h4);
        chk("u4 retained word", instr[1], 32'h012B_0A93);

        for (int i = 0; i < 13; i++) begin
            PC_Out = fv[i].pc;
            tick();
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("vec%0d u%0d fault", i, d), 32'(flt[d]), 32'(fv[i].f[d]));
                chk($sformatf("vec%0d u%0d instr", i, d), instr[d],
                    fv[i].f[d] ? NOP : mdl[d][fv[i].pc >> 2]);
            end
        end

        q = {};
        for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
        load(q, 1'b1);
        sweep();

        for (int it = 0; it < 3; it++) begin
            q = {};
            repeat ($urandom_range(1, 40)) q.push_back(8'($urandom));
            load(q, 1'b1);
            sweep();
        end

        // combinational instance faults at once, registered one an edge later
        lat_pc = '{32'h2, 32'h400};
        for (int k = 0; k < 2; k++) begin
            fetch_check(32'h4);
            PC_Out = lat_pc[k];
            #1;
            chk($sformatf("lat%0d u16 fault now", k), 32'(flt[0]), 32'd1);
            chk($sformatf("lat%0d u16 nop now", k), instr[0], NOP);
            chk($sformatf("lat%0d u256r fault held", k), 32'(flt[2]), 32'd0);
            chk($sformatf("lat%0d u256r instr held", k), instr[2], mdl[2][1]);
            tick();
            chk($sformatf("lat%0d u256r fault late", k), 32'(flt[2]), 32'd1);
            chk($sformatf("lat%0d u256r nop late", k), instr[2], NOP);
        end

        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        load(q, 1'b0);
        reset_and_clear();
        sweep();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
